// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 constants, opcodes and fetch FSM encoding
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    FETCH_REQ  = 1'b0,
    FETCH_WAIT = 1'b1
  } fetchState_e;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus
interface fetch_stage_if;
  import rv32_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with one-entry holding buffer
module if_id_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            rspLoad,
  input  logic [XLEN-1:0] rspPc,
  input  logic [XLEN-1:0] rspInstr,
  output logic            ifIdValid,
  output logic [XLEN-1:0] ifIdPc,
  output logic [XLEN-1:0] ifIdInstr,
  output logic            bufFull
);

  logic [XLEN-1:0] bufPc;
  logic [XLEN-1:0] bufInstr;
  logic            advance;

  // An empty IF/ID never stalls; the buffer only fills behind a stalled live entry.
  assign advance = !ifIdValid || !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifIdValid <= 1'b0;
      ifIdPc    <= '0;
      ifIdInstr <= '0;
      bufFull   <= 1'b0;
      bufPc     <= '0;
      bufInstr  <= '0;
    end else if (flush) begin
      ifIdValid <= 1'b0;
      bufFull   <= 1'b0;
    end else if (advance) begin
      if (bufFull) begin
        ifIdValid <= 1'b1;
        ifIdPc    <= bufPc;
        ifIdInstr <= bufInstr;
        bufFull   <= rspLoad;
        if (rspLoad) begin
          bufPc    <= rspPc;
          bufInstr <= rspInstr;
        end
      end else if (rspLoad) begin
        ifIdValid <= 1'b1;
        ifIdPc    <= rspPc;
        ifIdInstr <= rspInstr;
      end else begin
        ifIdValid <= 1'b0;
      end
    end else if (rspLoad) begin
      bufFull  <= 1'b1;
      bufPc    <= rspPc;
      bufInstr <= rspInstr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 fetch stage: PC, imem request FSM, redirect and IF/ID
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [XLEN-1:0]      branch_target,
  output logic                 if_id_valid,
  output logic [XLEN-1:0]      if_id_pc,
  output logic [XLEN-1:0]      if_id_instr,
  output logic [6:0]           opcode
);
  import rv32_pkg::*;

  fetchState_e     state;
  fetchState_e     stateNext;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetchPc;
  logic            kill;
  logic            bufFull;
  logic            reqValid;
  logic            reqFire;
  logic            rspFire;
  logic            rspLoad;

  // Gated by rst_n so the bus sees no request while reset is held.
  assign reqValid = rst_n && (state == FETCH_REQ) && !bufFull;
  assign reqFire  = reqValid && imem.imem_req_ready;
  assign rspFire  = (state == FETCH_WAIT) && imem.imem_rsp_valid;
  assign rspLoad  = rspFire && !kill && !branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH_REQ;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      FETCH_REQ:  if (reqFire) stateNext = FETCH_WAIT;
      FETCH_WAIT: if (imem.imem_rsp_valid) stateNext = FETCH_REQ;
      default:    stateNext = FETCH_REQ;
    endcase
  end

  always_comb begin
    imem.imem_req_valid = reqValid;
    imem.imem_addr      = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      fetchPc <= '0;
      kill    <= 1'b0;
    end else begin
      if (branch_taken)  pc <= wordAlign(branch_target);
      else if (reqFire)  pc <= pc + XLEN'(4);
      if (reqFire) fetchPc <= pc;
      // A redirect poisons whichever response is still owed to the old path.
      if (branch_taken)  kill <= reqFire || ((state == FETCH_WAIT) && !imem.imem_rsp_valid);
      else if (rspFire)  kill <= 1'b0;
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (branch_taken),
    .rspLoad   (rspLoad),
    .rspPc     (fetchPc),
    .rspInstr  (imem.imem_rsp_data),
    .ifIdValid (if_id_valid),
    .ifIdPc    (if_id_pc),
    .ifIdInstr (if_id_instr),
    .bufFull   (bufFull)
  );

  assign opcode = if_id_valid ? if_id_instr[6:0] : OP_NOP;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [6:0]  opcode;

  int total = 0;
  int bad = 0;
  int rspDelay = 1;

  fetch_stage_if imem ();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .opcode        (opcode)
  );

  always #5 clk = ~clk;

  // Memory model: word = {addr[24:0], opcode chosen by addr[3:2]}
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [6:0] op;
    case (a[3:2])
      2'd0:    op = 7'h33;
      2'd1:    op = 7'h03;
      2'd2:    op = 7'h23;
      default: op = 7'h63;
    endcase
    return {a[24:0], op};
  endfunction

  logic        pend;
  logic [31:0] pendAddr;
  int          cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pendAddr <= 32'h0;
      cnt      <= 0;
    end else if (imem.imem_req_valid && imem.imem_req_ready) begin
      pend     <= 1'b1;
      pendAddr <= imem.imem_addr;
      cnt      <= rspDelay - 1;
    end else if (pend && cnt == 0) begin
      pend <= 1'b0;
    end else if (pend) begin
      cnt <= cnt - 1;
    end
  end

  assign imem.imem_rsp_valid = pend && (cnt == 0);
  assign imem.imem_rsp_data  = memWord(pendAddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    imem.imem_req_ready = 1'b1;
    rspDelay = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    int          dly;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eIfv;
    logic [31:0] ePc;
    logic [6:0]  eOp;
  } vec_t;

  vec_t vecs[19];

  initial begin
    //          st  br  tgt           rdy dly eReq eAddr         eIfv ePc           eOp
    vecs[0]  = '{0, 0, 32'h0,        1, 1,  1, 32'h0,        0, 32'h0,        7'h00};
    vecs[1]  = '{0, 0, 32'h0,        1, 1,  0, 32'h0,        0, 32'h0,        7'h00};
    vecs[2]  = '{0, 0, 32'h0,        1, 1,  1, 32'h4,        1, 32'h0,        7'h33};
    vecs[3]  = '{0, 0, 32'h0,        1, 1,  0, 32'h0,        0, 32'h0,        7'h00};
    vecs[4]  = '{0, 0, 32'h0,        1, 1,  1, 32'h8,        1, 32'h4,        7'h03};
    vecs[5]  = '{0, 0, 32'h0,        1, 1,  0, 32'h0,        0, 32'h0,        7'h00};
    vecs[6]  = '{1, 0, 32'h0,        1, 1,  1, 32'hC,        1, 32'h8,        7'h23};
    vecs[7]  = '{1, 0, 32'h0,        1, 1,  0, 32'h0,        1, 32'h8,        7'h23};
    vecs[8]  = '{1, 0, 32'h0,        1, 1,  0, 32'h0,        1, 32'h8,        7'h23};
    vecs[9]  = '{0, 0, 32'h0,        1, 1,  0, 32'h0,        1, 32'h8,        7'h23};
    vecs[10] = '{0, 0, 32'h0,        1, 1,  1, 32'h10,       1, 32'hC,        7'h63};
    vecs[11] = '{0, 0, 32'h0,        1, 1,  0, 32'h0,        0, 32'h0,        7'h00};
    vecs[12] = '{0, 0, 32'h0,        1, 3,  1, 32'h14,       1, 32'h10,       7'h33};
    vecs[13] = '{0, 1, 32'h103,      1, 3,  0, 32'h0,        0, 32'h0,        7'h00};
    vecs[14] = '{0, 0, 32'h0,        1, 3,  0, 32'h0,        0, 32'h0,        7'h00};
    vecs[15] = '{0, 0, 32'h0,        1, 1,  0, 32'h0,        0, 32'h0,        7'h00};
    vecs[16] = '{0, 0, 32'h0,        1, 1,  1, 32'h100,      0, 32'h0,        7'h00};
    vecs[17] = '{0, 0, 32'h0,        1, 1,  0, 32'h0,        0, 32'h0,        7'h00};
    vecs[18] = '{0, 0, 32'h0,        1, 1,  1, 32'h104,      1, 32'h100,      7'h33};

    imem.imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_reqv", {31'h0, imem.imem_req_valid}, 32'h0);
    chk("rst_ifv", {31'h0, if_id_valid}, 32'h0);
    chk("rst_ifpc", if_id_pc, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_op", {25'h0, opcode}, 32'h0);

    // Table: basic fetch, stall into buffer, redirect while waiting
    doReset();
    for (int i = 0; i < 19; i++) begin
      stall = vecs[i].st;
      branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt;
      imem.imem_req_ready = vecs[i].rdy;
      rspDelay = vecs[i].dly;
      chk($sformatf("v%0d_reqv", i), {31'h0, imem.imem_req_valid}, {31'h0, vecs[i].eReq});
      if (vecs[i].eReq) chk($sformatf("v%0d_addr", i), imem.imem_addr, vecs[i].eAddr);
      chk($sformatf("v%0d_ifv", i), {31'h0, if_id_valid}, {31'h0, vecs[i].eIfv});
      if (vecs[i].eIfv) chk($sformatf("v%0d_ifpc", i), if_id_pc, vecs[i].ePc);
      chk($sformatf("v%0d_op", i), {25'h0, opcode}, {25'h0, vecs[i].eOp});
      if (i == 2) chk("v2_instr", if_id_instr, 32'h0000_0033);
      step();
    end
    branch_taken = 1'b0;

    // Branch and stall together with the holding buffer full
    doReset();
    stall = 1'b1;
    step(); step();
    chk("bs_reqv_c2", {31'h0, imem.imem_req_valid}, 32'h1);
    chk("bs_addr_c2", imem.imem_addr, 32'h4);
    chk("bs_ifpc_c2", if_id_pc, 32'h0);
    step(); step();
    chk("bs_noreq_full", {31'h0, imem.imem_req_valid}, 32'h0);
    chk("bs_ifv_hold", {31'h0, if_id_valid}, 32'h1);
    chk("bs_ifpc_hold", if_id_pc, 32'h0);
    branch_taken = 1'b1;
    branch_target = 32'h203;
    step();
    branch_taken = 1'b0;
    stall = 1'b0;
    chk("bs_ifv_flush", {31'h0, if_id_valid}, 32'h0);
    chk("bs_reqv_tgt", {31'h0, imem.imem_req_valid}, 32'h1);
    chk("bs_addr_tgt", imem.imem_addr, 32'h200);
    step(); step();
    chk("bs_ifv_tgt", {31'h0, if_id_valid}, 32'h1);
    chk("bs_ifpc_tgt", if_id_pc, 32'h200);
    chk("bs_op_tgt", {25'h0, opcode}, 32'h33);

    // Branch in the same cycle a request is accepted
    doReset();
    branch_taken = 1'b1;
    branch_target = 32'h40;
    chk("ka_addr0", imem.imem_addr, 32'h0);
    step();
    branch_taken = 1'b0;
    chk("ka_ifv_c1", {31'h0, if_id_valid}, 32'h0);
    step();
    chk("ka_ifv_c2", {31'h0, if_id_valid}, 32'h0);
    chk("ka_reqv_c2", {31'h0, imem.imem_req_valid}, 32'h1);
    chk("ka_addr_c2", imem.imem_addr, 32'h40);
    step(); step();
    chk("ka_ifv_c4", {31'h0, if_id_valid}, 32'h1);
    chk("ka_ifpc_c4", if_id_pc, 32'h40);

    // PC wrap at the top of the address space
    doReset();
    imem.imem_req_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    step();
    branch_taken = 1'b0;
    imem.imem_req_ready = 1'b1;
    chk("wr_addr_top", imem.imem_addr, 32'hFFFF_FFFC);
    step(); step();
    chk("wr_reqv", {31'h0, imem.imem_req_valid}, 32'h1);
    chk("wr_addr_wrap", imem.imem_addr, 32'h0);
    chk("wr_ifpc", if_id_pc, 32'hFFFF_FFFC);
    chk("wr_op", {25'h0, opcode}, 32'h63);

    // Asynchronous reset while waiting with a live IF/ID entry
    doReset();
    rspDelay = 3;
    step(); step(); step(); step();
    stall = 1'b1;
    chk("ar_ifv_c4", {31'h0, if_id_valid}, 32'h1);
    step();
    chk("ar_wait_reqv", {31'h0, imem.imem_req_valid}, 32'h0);
    chk("ar_wait_ifv", {31'h0, if_id_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_reqv", {31'h0, imem.imem_req_valid}, 32'h0);
    chk("ar_ifv", {31'h0, if_id_valid}, 32'h0);
    chk("ar_ifpc", if_id_pc, 32'h0);
    chk("ar_instr", if_id_instr, 32'h0);
    chk("ar_op", {25'h0, opcode}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    rspDelay = 1;
    #1;
    chk("ar_rel_reqv", {31'h0, imem.imem_req_valid}, 32'h1);
    chk("ar_rel_addr", imem.imem_addr, 32'h0);
    step(); step();
    chk("ar_rel_ifpc", if_id_pc, 32'h0);
    chk("ar_rel_instr", if_id_instr, 32'h0000_0033);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage and IF/ID pipeline register for the 32-bit RISC-V core.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request with an in-order response.
- Buffers returned instructions and presents the IF/ID instruction, PC and opcode field directly to the downstream control unit.
- Handles decode stalls and branch redirects, with branch flush taking priority.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, address and instruction width. Only 32 is supported.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  word-aligned fetch address, bits[1:0]=00.
- imem_rsp_valid  in  1  response valid, in order, at most 1 outstanding.
- imem_rsp_data  in  XLEN  fetched instruction.
- stall  in  1  decode cannot accept; hold IF/ID.
- branch_taken  in  1  redirect request, one-cycle pulse.
- branch_target  in  XLEN  redirect PC; bits[1:0] forced to 00.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_pc  out  XLEN  PC of the IF/ID instruction.
- if_id_instr  out  XLEN  IF/ID instruction.
- opcode  out  7  if_id_instr[6:0] when if_id_valid, else 7'b0000000 (control unit treats this as NOP).

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=REQ, imem_req_valid=0 during reset.
  - if_id_valid=0, if_id_pc=0, if_id_instr=0, opcode=0.
  - Holding buffer empty, kill flag=0.
- FSM states:
  - REQ: imem_req_valid=1 and imem_addr=pc, unless the buffer is full. Request handshake (valid&ready) -> WAIT; fetch_pc<=pc, pc<=pc+4.
  - WAIT: imem_req_valid=0. On imem_rsp_valid -> REQ.
- Response routing in WAIT, on imem_rsp_valid:
  - Kill flag set: discard the response, clear kill.
  - Else, IF/ID empty, or IF/ID full with stall=0: load IF/ID with {fetch_pc, rsp_data}.
  - Else (IF/ID full and stall=1): load the holding buffer.
- Stall and buffer:
  - IF/ID advances each cycle stall=0.
  - Next IF/ID source priority: buffer, then response, else if_id_valid<=0.
  - REQ does not issue while the buffer is full. The buffer therefore never overflows.
- Branch (highest priority, the cycle branch_taken=1):
  - pc<=branch_target & ~3.
  - if_id_valid<=0, buffer cleared, state<=REQ.
  - If state is WAIT and the response has not arrived this cycle, kill<=1 and state stays WAIT until that response drains.
  - A same-cycle response is discarded.
  - An accepted request that same cycle is also killed.
- Branch overrides stall. Stall is ignored while if_id_valid=0.
- Latency: request accepted at cycle N with response at N+k gives if_id_valid at N+k+1. Sustained throughput is 1 instr per 2 cycles (one outstanding).
- PC arithmetic: PC wraps 32'hFFFF_FFFC -> 32'h0000_0000; no trap.
- Reset mid-WAIT: outstanding response is ignored by protocol. The memory must also be reset.

Decomposition:
- Shared package (rv32_pkg) holds:
  - XLEN, RESET_PC default.
  - NOP opcode 7'b0000000.
  - Opcode constants OP_RTYPE 7'b0110011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011.
  - Fetch FSM state encoding.
- One sub-module: if_id_reg. It contains the IF/ID register plus the holding buffer, with stall/flush inputs. PC/FSM logic stays in fetch_stage.

Test Plan:
- Reset release, imem ready=1, 1-cycle response returning 32'h00000033:
  - First imem_addr=0.
  - if_id_pc=0, if_id_instr=32'h00000033, opcode=7'b0110011.
  - Next addr=4.
- Stall held 3 cycles with IF/ID full at pc=8:
  - Response for pc=12 goes to the buffer; no request issued.
  - After stall drops, IF/ID shows pc=12, then the fetch of 16 proceeds.
- Branch to 32'h00000103 while WAIT for pc=20:
  - pc=20 response discarded, if_id_valid=0.
  - Next imem_addr=32'h00000100.
- Branch and stall asserted in the same cycle with the buffer full:
  - Buffer and IF/ID cleared.
  - Fetch resumes at target.
- PC at 32'hFFFFFFFC fetched:
  - Next imem_addr=0, no error.
- rst_n asserted asynchronously mid-WAIT with IF/ID valid:
  - All outputs zero immediately.
  - After release, first fetch at RESET_PC.
